mc_control_fsm: RTL

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS-subset control unit (Moore FSM).
//
// Ports:
//   clk, rst             - rising-edge clock, async active-high reset
//   opcode, funct        - IR[31:26] / IR[5:0], valid from DECODE onward
//   zero, overflow       - ALU flags, combinational in the same cycle
//   PCWrite..MemtoReg    - 1-bit datapath write/select controls
//   ALUSrcA, ALUSrcB     - ALU operand selects
//   ALUOp, ExtOp         - ALU operation / immediate extension mode
//   PCSource             - PC next-value select
//   state                - current FSM state encoding
//   halted               - high while in HALT
//   instr_count          - retired instruction count (wraps at 2^32)
module mc_control_fsm #(
    parameter int unsigned HALT_ON_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        overflow,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  ExtOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        EXEC_I   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam state_t ILLEGAL_NEXT = (HALT_ON_ILLEGAL != 0) ? HALT : FETCH;

    state_t      cur, nxt;
    logic [5:0]  op_q, fn_q;
    logic        ovf_flag;
    logic        retire;

    // zero qualifies PCWriteCond in the datapath; the FSM itself never needs it.
    logic unused_zero;
    assign unused_zero = zero;

    // Every state listed here transitions unconditionally into FETCH.
    assign retire = (cur == MEM_WB) || (cur == MEM_WR) || (cur == R_WB) ||
                    (cur == I_WB)   || (cur == BRANCH) || (cur == JUMP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= FETCH;
            op_q        <= '0;
            fn_q        <= '0;
            ovf_flag    <= 1'b0;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            ovf_flag <= (cur == EXEC_I) && overflow && (op_q == OP_ADDI);
            if (retire)
                instr_count <= instr_count + 32'd1;
        end
    end

    always_comb begin
        nxt         = cur;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        ExtOp       = 2'b00;
        PCSource    = 2'b00;

        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
                nxt     = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ExtOp   = 2'b01;
                // IR was loaded at the end of FETCH, so dispatch on the live opcode.
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_ADDU || funct == FN_SUBU || funct == FN_SLT)
                            nxt = EXEC_R;
                        else
                            nxt = ILLEGAL_NEXT;
                    end
                    OP_LW, OP_SW:                     nxt = MEM_ADDR;
                    OP_ORI, OP_LUI, OP_ADDI, OP_ADDIU: nxt = EXEC_I;
                    OP_BEQ:                           nxt = BRANCH;
                    OP_J:                             nxt = JUMP;
                    default:                          nxt = ILLEGAL_NEXT;
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ExtOp   = 2'b01;
                nxt     = (op_q == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = MEM_WB;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt      = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nxt      = FETCH;
            end
            EXEC_R: begin
                ALUSrcA = 2'b01;
                case (fn_q)
                    FN_SUBU: ALUOp = 3'b001;
                    FN_SLT:  ALUOp = 3'b011;
                    default: ALUOp = 3'b000;
                endcase
                nxt = R_WB;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                nxt      = FETCH;
            end
            EXEC_I: begin
                ALUSrcB = 2'b10;
                case (op_q)
                    OP_ORI: begin
                        ALUSrcA = 2'b01;
                        ALUOp   = 3'b010;
                    end
                    OP_LUI: begin
                        ALUSrcA = 2'b10;
                        ExtOp   = 2'b10;
                        ALUOp   = 3'b010;
                    end
                    OP_ADDI: begin
                        ALUSrcA = 2'b01;
                        ExtOp   = 2'b01;
                        ALUOp   = 3'b100;
                    end
                    default: begin
                        ALUSrcA = 2'b01;
                        ExtOp   = 2'b01;
                    end
                endcase
                nxt = I_WB;
            end
            I_WB: begin
                // An overflowing addi still retires but must not update the register file.
                RegWrite = ~ovf_flag;
                nxt      = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 2'b01;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                nxt         = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                nxt      = FETCH;
            end
            HALT: nxt = HALT;
            default: nxt = FETCH;
        endcase

        // Reset parks the FSM in FETCH; suppress FETCH's enables while rst is held.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign state  = cur;
    assign halted = (cur == HALT);

endmodule
